// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Decode/issue stage between register-file read and the ALU. It decodes RV32I
// R-type, I-type ALU, LUI/AUIPC and BEQ/BNE/BLT/BGE into the 4-bit ALU
// encoding and assembles the {op, opA, opB} bundle plus branch target and
// writeback control. Decoded bundles go into a 2-entry skid buffer with
// valid/ready handshakes on both sides. Latency is 1 cycle and throughput is
// 1 per cycle.
//
// Configuration macro: ALU_ILLEGAL_TRAP_EN
//   defined   : out_illegal port exists; unsupported encodings are enqueued
//               with out_illegal=1 and zeroed op/operands/we.
//   undefined : no out_illegal port; unsupported encodings become a NOP.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   flush               drop all buffered entries and any same-cycle input
//   in_valid/in_ready   upstream handshake (in_ready = buffer not full)
//   in_instr, in_pc     raw instruction and its PC
//   in_rs1_data/rs2     register-file read data
//   out_valid/out_ready downstream handshake on the head entry
//   out_op              0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,
//                       8 BEQ,9 BNE,A BLT,B BGE
//   out_opA, out_opB    ALU operands
//   out_is_branch       op is a branch compare
//   out_br_target       pc + B-immediate for branches, else 0
//   out_rd, out_we      destination register and writeback enable
//   out_pc              passthrough PC
//   out_illegal         unsupported encoding (only with ALU_ILLEGAL_TRAP_EN)
// -----------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int XLEN       = 32,
  parameter int SKID_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_op,
  output logic [XLEN-1:0] out_opA,
  output logic [XLEN-1:0] out_opB,
  output logic            out_is_branch,
  output logic [XLEN-1:0] out_br_target,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic [XLEN-1:0] out_pc
`ifdef ALU_ILLEGAL_TRAP_EN
  ,
  output logic            out_illegal
`endif
);

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_XOR = 4'h4, OP_SLL = 4'h5, OP_SRL = 4'h6, OP_SRA = 4'h7,
    OP_BEQ = 4'h8, OP_BNE = 4'h9, OP_BLT = 4'hA, OP_BGE = 4'hB
  } alu_op_e;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;

  localparam logic [1:0] LP_FULL   = 2'(SKID_DEPTH);

  typedef struct packed {
    alu_op_e         op;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic            is_branch;
    logic [XLEN-1:0] br_target;
    logic [4:0]      rd;
    logic            we;
    logic [XLEN-1:0] pc;
`ifdef ALU_ILLEGAL_TRAP_EN
    logic            illegal;
`endif
  } entry_t;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rd_field;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_shamt;
  logic            w_unused_rs1_idx;

  assign w_opcode   = in_instr[6:0];
  assign w_funct3   = in_instr[14:12];
  assign w_funct7   = in_instr[31:25];
  assign w_rd_field = in_instr[11:7];
  assign w_imm_i    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign w_imm_u    = {in_instr[31:12], 12'b0};
  assign w_imm_b    = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_shamt    = {{(XLEN-5){1'b0}}, in_instr[24:20]};
  // Register indices are resolved upstream; only the read data is used here.
  assign w_unused_rs1_idx = &{1'b0, in_instr[19:15]};

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic            w_legal;
  alu_op_e         w_op;
  logic [XLEN-1:0] w_opa;
  logic [XLEN-1:0] w_opb;
  logic            w_is_br;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    w_legal = 1'b0;
    w_op    = OP_ADD;
    w_opa   = '0;
    w_opb   = '0;
    w_is_br = 1'b0;
    case (w_opcode)
      OPC_R: begin
        w_legal = 1'b1;
        w_opa   = in_rs1_data;
        w_opb   = in_rs2_data;
        case ({w_funct7, w_funct3})
          {7'h00, 3'b000}: w_op = OP_ADD;
          {7'h20, 3'b000}: w_op = OP_SUB;
          {7'h00, 3'b001}: w_op = OP_SLL;
          {7'h00, 3'b100}: w_op = OP_XOR;
          {7'h00, 3'b101}: w_op = OP_SRL;
          {7'h20, 3'b101}: w_op = OP_SRA;
          {7'h00, 3'b110}: w_op = OP_OR;
          {7'h00, 3'b111}: w_op = OP_AND;
          default:         w_legal = 1'b0;   // SLT/SLTU and bad funct7
        endcase
      end
      OPC_I: begin
        w_legal = 1'b1;
        w_opa   = in_rs1_data;
        w_opb   = w_imm_i;
        case (w_funct3)
          3'b000: w_op = OP_ADD;
          3'b100: w_op = OP_XOR;
          3'b110: w_op = OP_OR;
          3'b111: w_op = OP_AND;
          3'b001: begin
            w_op    = OP_SLL;
            w_opb   = w_shamt;
            w_legal = (w_funct7 == 7'h00);
          end
          3'b101: begin
            w_opb = w_shamt;
            if (w_funct7 == 7'h00)      w_op = OP_SRL;
            else if (w_funct7 == 7'h20) w_op = OP_SRA;
            else                        w_legal = 1'b0;
          end
          default: w_legal = 1'b0;          // SLTI/SLTIU
        endcase
      end
      OPC_LUI: begin
        w_legal = 1'b1;
        w_opb   = w_imm_u;
      end
      OPC_AUIPC: begin
        w_legal = 1'b1;
        w_opa   = in_pc;
        w_opb   = w_imm_u;
      end
      OPC_BR: begin
        w_legal = 1'b1;
        w_is_br = 1'b1;
        w_opa   = in_rs1_data;
        w_opb   = in_rs2_data;
        case (w_funct3)
          3'b000:  w_op = OP_BEQ;
          3'b001:  w_op = OP_BNE;
          3'b100:  w_op = OP_BLT;
          3'b101:  w_op = OP_BGE;
          default: w_legal = 1'b0;          // BLTU/BGEU
        endcase
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Unsupported encodings collapse to an all-zero NOP bundle.
  entry_t w_entry;

  always_comb begin
    w_entry           = '0;
    w_entry.pc        = in_pc;
`ifdef ALU_ILLEGAL_TRAP_EN
    w_entry.illegal   = ~w_legal;
`endif
    if (w_legal) begin
      w_entry.op        = w_op;
      w_entry.opa       = w_opa;
      w_entry.opb       = w_opb;
      w_entry.is_branch = w_is_br;
      w_entry.br_target = w_is_br ? (in_pc + w_imm_b) : '0;
      w_entry.rd        = w_is_br ? 5'd0 : w_rd_field;
      w_entry.we        = ~w_is_br && (w_rd_field != 5'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Skid buffer: two entries addressed by 1-bit read/write pointers
  // ---------------------------------------------------------------------------
  entry_t     r_mem [SKID_DEPTH];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  // in_ready depends only on the registered count, never on out_ready.
  assign in_ready  = (r_count != LP_FULL);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      // NOTE: the storage is reset too because the head entry drives the
      // out_* data pins, which must read zero out of reset.
      for (int i = 0; i < SKID_DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      // Flush overrides any same-cycle push and pop.
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Head entry drives the outputs
  // ---------------------------------------------------------------------------
  entry_t w_head;

  assign w_head        = r_mem[r_rd_ptr];
  assign out_op        = w_head.op;
  assign out_opA       = w_head.opa;
  assign out_opB       = w_head.opb;
  assign out_is_branch = w_head.is_branch;
  assign out_br_target = w_head.br_target;
  assign out_rd        = w_head.rd;
  assign out_we        = w_head.we;
  assign out_pc        = w_head.pc;
`ifdef ALU_ILLEGAL_TRAP_EN
  assign out_illegal   = w_head.illegal;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Directed bench for alu_issue_stage: a table of single-instruction vectors
// with hand-computed expected bundles, followed by hand-written sequences for
// back-pressure, flush and mid-operation reset. Build with
// ALU_ILLEGAL_TRAP_EN defined to also check out_illegal.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [31:0] out_opA;
  logic [31:0] out_opB;
  logic        out_is_branch;
  logic [31:0] out_br_target;
  logic [4:0]  out_rd;
  logic        out_we;
  logic [31:0] out_pc;
`ifdef ALU_ILLEGAL_TRAP_EN
  logic        out_illegal;
`endif

  alu_issue_stage #(.XLEN(32), .SKID_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .in_rs1_data   (in_rs1_data),
    .in_rs2_data   (in_rs2_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_op        (out_op),
    .out_opA       (out_opA),
    .out_opB       (out_opB),
    .out_is_branch (out_is_branch),
    .out_br_target (out_br_target),
    .out_rd        (out_rd),
    .out_we        (out_we),
    .out_pc        (out_pc)
`ifdef ALU_ILLEGAL_TRAP_EN
    ,
    .out_illegal   (out_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        is_br;
    logic [31:0] tgt;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic drive_in(input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid    = 1'b1;
    in_instr    = instr;
    in_pc       = pc;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
  endtask

  initial begin
    //               name     instr          pc            rs1           rs2          op    opA           opB           br    tgt           rd  we    ill
    vecs[0]  = '{"add",     32'h002081B3, 32'h0000_0000, 32'd5,        32'd7,       4'h0, 32'd5,        32'd7,        1'b0, 32'h0,        5'd3, 1'b1, 1'b0};
    vecs[1]  = '{"sub",     32'h407302B3, 32'h0000_0004, 32'd10,       32'd3,       4'h1, 32'd10,       32'd3,        1'b0, 32'h0,        5'd5, 1'b1, 1'b0};
    vecs[2]  = '{"srai",    32'h4040D093, 32'h0000_0008, 32'h80000000, 32'd9,       4'h7, 32'h80000000, 32'd4,        1'b0, 32'h0,        5'd1, 1'b1, 1'b0};
    vecs[3]  = '{"blt",     32'hFE20CCE3, 32'h0000_0100, 32'd1,        32'd2,       4'hA, 32'd1,        32'd2,        1'b1, 32'h000000F8, 5'd0, 1'b0, 1'b0};
    vecs[4]  = '{"addi",    32'hFFF00113, 32'h0000_0010, 32'h11,       32'h22,      4'h0, 32'h11,       32'hFFFFFFFF, 1'b0, 32'h0,        5'd2, 1'b1, 1'b0};
    vecs[5]  = '{"lui",     32'h12345237, 32'h0000_0014, 32'h99,       32'h77,      4'h0, 32'h0,        32'h12345000, 1'b0, 32'h0,        5'd4, 1'b1, 1'b0};
    vecs[6]  = '{"auipc",   32'h00001217, 32'h0000_2000, 32'h99,       32'h77,      4'h0, 32'h2000,     32'h1000,     1'b0, 32'h0,        5'd4, 1'b1, 1'b0};
    vecs[7]  = '{"add_x0",  32'h00208033, 32'h0000_0018, 32'd5,        32'd7,       4'h0, 32'd5,        32'd7,        1'b0, 32'h0,        5'd0, 1'b0, 1'b0};
    vecs[8]  = '{"sltu",    32'h0020B1B3, 32'h0000_001C, 32'd5,        32'd7,       4'h0, 32'h0,        32'h0,        1'b0, 32'h0,        5'd0, 1'b0, 1'b1};
    vecs[9]  = '{"bge_wrap",32'h0020D863, 32'hFFFFFFF8, 32'd3,        32'd4,       4'hB, 32'd3,        32'd4,        1'b1, 32'h00000008, 5'd0, 1'b0, 1'b0};
    vecs[10] = '{"srli_bad",32'h0240D093, 32'h0000_0020, 32'd5,        32'd7,       4'h0, 32'h0,        32'h0,        1'b0, 32'h0,        5'd0, 1'b0, 1'b1};
    vecs[11] = '{"xori",    32'h0F00C313, 32'h0000_0024, 32'hFF,       32'd1,       4'h4, 32'hFF,       32'hF0,       1'b0, 32'h0,        5'd6, 1'b1, 1'b0};
    vecs[12] = '{"sll",     32'h002093B3, 32'h0000_0028, 32'd1,        32'd31,      4'h5, 32'd1,        32'd31,       1'b0, 32'h0,        5'd7, 1'b1, 1'b0};
    vecs[13] = '{"and",     32'h0020F3B3, 32'h0000_002C, 32'hF0F0,     32'h0FF0,    4'h2, 32'hF0F0,     32'h0FF0,     1'b0, 32'h0,        5'd7, 1'b1, 1'b0};
    vecs[14] = '{"bad_opc", 32'h0000007F, 32'h0000_0030, 32'd5,        32'd7,       4'h0, 32'h0,        32'h0,        1'b0, 32'h0,        5'd0, 1'b0, 1'b1};
  end

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_instr    = '0;
    in_pc       = '0;
    in_rs1_data = '0;
    in_rs2_data = '0;
    out_ready   = 1'b0;

    // ---- reset state, sampled while reset is held ----
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_op",    32'(out_op), 32'd0);
    check("rst_out_opA",   out_opA, 32'd0);
    check("rst_out_opB",   out_opB, 32'd0);
    check("rst_out_we",    32'(out_we), 32'd0);
    check("rst_out_pc",    out_pc, 32'd0);
`ifdef ALU_ILLEGAL_TRAP_EN
    check("rst_out_illegal", 32'(out_illegal), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // ---- table vectors: push one, check one cycle later, pop it ----
    for (int i = 0; i < NV; i++) begin
      drive_in(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      @(negedge clk);
      in_valid = 1'b0;
      check({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
      check({vecs[i].name, "_op"},    32'(out_op), 32'(vecs[i].op));
      check({vecs[i].name, "_opA"},   out_opA, vecs[i].opa);
      check({vecs[i].name, "_opB"},   out_opB, vecs[i].opb);
      check({vecs[i].name, "_isbr"},  32'(out_is_branch), 32'(vecs[i].is_br));
      check({vecs[i].name, "_tgt"},   out_br_target, vecs[i].tgt);
      check({vecs[i].name, "_rd"},    32'(out_rd), 32'(vecs[i].rd));
      check({vecs[i].name, "_we"},    32'(out_we), 32'(vecs[i].we));
      check({vecs[i].name, "_pc"},    out_pc, vecs[i].pc);
`ifdef ALU_ILLEGAL_TRAP_EN
      check({vecs[i].name, "_ill"},   32'(out_illegal), 32'(vecs[i].ill));
`endif
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({vecs[i].name, "_popped"}, 32'(out_valid), 32'd0);
    end

    // ---- back-pressure: three back-to-back pushes with out_ready low ----
    drive_in(32'h002081B3, 32'h300, 32'd100, 32'd1);
    @(negedge clk);
    check("bp_ready_after1", 32'(in_ready), 32'd1);
    drive_in(32'h002081B3, 32'h304, 32'd101, 32'd1);
    @(negedge clk);
    check("bp_ready_after2", 32'(in_ready), 32'd0);
    check("bp_head0", out_opA, 32'd100);
    drive_in(32'h002081B3, 32'h308, 32'd102, 32'd1);
    @(negedge clk);
    check("bp_stalled_ready", 32'(in_ready), 32'd0);
    check("bp_head0_held", out_opA, 32'd100);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_head1", out_opA, 32'd101);
    check("bp_head1_pc", out_pc, 32'h304);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_head2", out_opA, 32'd102);
    check("bp_head2_pc", out_pc, 32'h308);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_drained", 32'(out_valid), 32'd0);

    // ---- flush with a full buffer and a same-cycle push ----
    drive_in(32'h002081B3, 32'h400, 32'd1, 32'd1);
    @(negedge clk);
    drive_in(32'h002081B3, 32'h404, 32'd2, 32'd1);
    @(negedge clk);
    check("fl_full", 32'(in_ready), 32'd0);
    drive_in(32'h002081B3, 32'h408, 32'd3, 32'd1);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready",  32'(in_ready), 32'd1);
    @(negedge clk);
    check("fl_input_dropped", 32'(out_valid), 32'd0);

    // ---- asynchronous reset mid-operation ----
    drive_in(32'h002081B3, 32'h500, 32'd55, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("ar_loaded", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_out_opA",   out_opA, 32'd0);
    check("ar_in_ready",  32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ar_stays_empty", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
